// File: rtl/serial_mag_comparator_ctrl.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator_ctrl
//
// Purpose:
//   Compares two WIDTH-bit unsigned operands one bit per clock, MSB first,
//   using a single 1-bit compare cell. Results are reported one-hot on
//   ans2 (A > B), ans1 (A == B) and ans0 (A < B) with a start/busy/done
//   handshake. This trades latency for area.
//
// Configuration macro:
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, the compare finishes at the
//   first differing bit pair instead of always walking all WIDTH bits.
//   Results are identical either way; only latency changes.
//
// Parameters:
//   WIDTH  operand width in bits (>= 1), default 8
//
// Ports:
//   clk    in   single system clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request a compare; sampled only when idle
//   a_in   in   operand A, latched on an accepted start
//   b_in   in   operand B, latched on an accepted start
//   busy   out  high from the accepted start through the done cycle
//   done   out  one-cycle pulse, results valid
//   ans2   out  A > B
//   ans1   out  A == B
//   ans0   out  A < B
// -----------------------------------------------------------------------------
module serial_mag_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             ans2,
    output logic             ans1,
    output logic             ans0
);

    // Counter holds WIDTH-1 down to 0; keep at least one bit for WIDTH = 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             decided_q, decided_d;
    logic             gt_res_q,  gt_res_d;
    logic             lt_res_q,  lt_res_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             ans2_q,    ans2_d;
    logic             ans1_q,    ans1_d;
    logic             ans0_q,    ans0_d;

    // The 1-bit compare cell operating on the current MSB pair.
    logic bit_a, bit_b;
    logic bit_gt, bit_eq, bit_lt;

    assign bit_a  = a_sh_q[WIDTH-1];
    assign bit_b  = b_sh_q[WIDTH-1];
    assign bit_gt = bit_a & ~bit_b;
    assign bit_eq = bit_a ~^ bit_b;
    assign bit_lt = ~bit_a & bit_b;

    // Exit-edge bookkeeping.
    logic last_bit;
    logic exit_run;
    logic final_decided;
    logic final_gt;
    logic final_lt;

    always_comb begin
        state_d       = state_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        cnt_d         = cnt_q;
        decided_d     = decided_q;
        gt_res_d      = gt_res_q;
        lt_res_d      = lt_res_q;
        busy_d        = busy_q;
        done_d        = done_q;
        ans2_d        = ans2_q;
        ans1_d        = ans1_q;
        ans0_d        = ans0_q;

        last_bit      = (cnt_q == '0);
        // The current bit decides the compare if nothing earlier did.
        final_decided = decided_q | ~bit_eq;
        final_gt      = decided_q ? gt_res_q : bit_gt;
        final_lt      = decided_q ? lt_res_q : bit_lt;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exit_run      = last_bit | (~decided_q & ~bit_eq);
`else
        exit_run      = last_bit;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d    = a_in;
                    b_sh_d    = b_in;
                    cnt_d     = CW'(WIDTH - 1);
                    decided_d = 1'b0;
                    gt_res_d  = 1'b0;
                    lt_res_d  = 1'b0;
                    ans2_d    = 1'b0;
                    ans1_d    = 1'b0;
                    ans0_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end

            RUN: begin
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q << 1;
                // Hold at zero rather than wrapping after the last bit.
                if (!last_bit) begin
                    cnt_d = cnt_q - 1'b1;
                end
                // First differing pair freezes the result; later bits
                // cannot change it.
                if (!decided_q && !bit_eq) begin
                    decided_d = 1'b1;
                    gt_res_d  = bit_gt;
                    lt_res_d  = bit_lt;
                end
                if (exit_run) begin
                    ans2_d  = final_decided & final_gt;
                    ans0_d  = final_decided & final_lt;
                    ans1_d  = ~final_decided;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                // Start is ignored here; one cycle of done then back to idle.
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_res_q  <= 1'b0;
            lt_res_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ans2_q    <= 1'b0;
            ans1_q    <= 1'b0;
            ans0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_res_q  <= gt_res_d;
            lt_res_q  <= lt_res_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ans2_q    <= ans2_d;
            ans1_q    <= ans1_d;
            ans0_q    <= ans0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ans2 = ans2_q;
    assign ans1 = ans1_q;
    assign ans0 = ans0_q;

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_mag_comparator_ctrl
//
// Self-checking bench for serial_mag_comparator_ctrl (WIDTH = 8). Expected
// results come from plain integer compares of the operands; expected latency
// comes from the position of the first differing bit (early-exit build) or
// is WIDTH (default build). Honours SERIAL_CMP_EARLY_EXIT_EN if defined.
// -----------------------------------------------------------------------------
module tb_serial_mag_comparator_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             ans2;
    logic             ans1;
    logic             ans0;

    int         checks   = 0;
    int         errors   = 0;
    logic [2:0] last_ans = 3'b000;

    serial_mag_comparator_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .ans2  (ans2),
        .ans1  (ans1),
        .ans0  (ans0)
    );

    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges from accept to done: index of first differing bit from the MSB
    // when early exit is enabled, otherwise always WIDTH.
    function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int j = 1; j <= WIDTH; j++) begin
            if (a[WIDTH-j] != b[WIDTH-j]) return j;
        end
`endif
        return WIDTH;
    endfunction

    function automatic logic [2:0] exp_ans(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {(a > b), (a == b), (a < b)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an idle cycle (1 ns after an edge), ends in the first idle
    // cycle after done, so calls can be chained back to back.
    task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit toggle);
        int         lat;
        bit         seen;
        int         got_lat;
        logic [2:0] ea;
        lat     = exp_latency(a, b);
        ea      = exp_ans(a, b);
        seen    = 1'b0;
        got_lat = 0;

        chk("pre_busy", {31'd0, busy}, 32'd0);
        chk("pre_ans_held", {29'd0, ans2, ans1, ans0}, {29'd0, last_ans});
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        step();  // accept edge
        chk("acc_busy", {31'd0, busy}, 32'd1);
        chk("acc_ans_clr", {29'd0, ans2, ans1, ans0}, 32'd0);
        if (!toggle) start = 1'b0;

        for (int k = 1; k <= WIDTH + 2 && !seen; k++) begin
            if (toggle) begin
                a_in = WIDTH'($urandom);
                b_in = WIDTH'($urandom);
            end
            step();
            if (done) begin
                seen    = 1'b1;
                got_lat = k;
                chk("latency", k, lat);
                chk("ans", {29'd0, ans2, ans1, ans0}, {29'd0, ea});
                chk("done_busy", {31'd0, busy}, 32'd1);
            end else begin
                chk("run_busy_ans", {28'd0, busy, ans2, ans1, ans0}, 32'h8);
            end
        end
        if (!seen) chk("timeout_no_done", 32'd0, 32'd1);
        last_ans = ea;

        step();  // leaves DONE; a held start here must be ignored
        chk("post_idle", {30'd0, busy, done}, 32'd0);
        chk("post_ans_held", {29'd0, ans2, ans1, ans0}, {29'd0, last_ans});
        start = 1'b0;
        $display("cmp a=%02h b=%02h toggle=%0d exp_ans=%03b exp_lat=%0d got_lat=%0d",
                 a, b, toggle, ea, lat, got_lat);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               sel;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        chk("reset_outputs", {27'd0, busy, done, ans2, ans1, ans0}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_after_reset", {27'd0, busy, done, ans2, ans1, ans0}, 32'd0);

        // Directed cases; consecutive calls are back-to-back compares.
        run_cmp(8'hA5, 8'hA5, 1'b0);
        run_cmp(8'h80, 8'h7F, 1'b0);
        run_cmp(8'h01, 8'h02, 1'b0);
        run_cmp(8'hC3, 8'h3C, 1'b1);
        run_cmp(8'h00, 8'h00, 1'b1);
        run_cmp(8'hFF, 8'hFE, 1'b0);
        run_cmp(8'h00, 8'h01, 1'b0);

        // Reset in the middle of a run: abort with no done pulse.
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'h00;
        step();  // E0
        start = 1'b0;
        step();  // E0+1
        step();  // E0+2
        rst = 1'b1;
        step();  // E0+3
        rst = 1'b0;
        chk("abort_cleared", {27'd0, busy, done, ans2, ans1, ans0}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_done", {30'd0, busy, done}, 32'd0);
        end
        $display("abort a=ff b=00 reset at E0+3");
        last_ans = 3'b000;
        run_cmp(8'h10, 8'h20, 1'b0);

        // Randomized compares, biased toward equal and near-equal operands.
        for (int n = 0; n < 40; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
            ra  = WIDTH'($urandom);
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      rb = ra;
            else if (sel == 1) rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            else               rb = WIDTH'($urandom);
            run_cmp(ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
